// File: rtl/row_dot_accum.sv
// row_dot_accum
// Consumes LANES-wide row chunks from the matrix buffer and multiplies each
// accepted beat lane-wise by a weight vector. It sums the lane products,
// accumulates those sums over a programmed number of beats, and presents one
// full-precision result on a valid/ready port. Upstream has no backpressure,
// so beats the block cannot use are dropped and flagged in a sticky flag.

module row_dot_accum #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 3,
  parameter int MAX_BEATS  = 8,
  parameter int BEAT_W     = $clog2(MAX_BEATS + 1),
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(LANES) + BEAT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [BEAT_W-1:0]                beats_i,
  input  logic                             data_valid,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] mem_row_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] weight_i,
  output logic [ACC_WIDTH-1:0]             result_o,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic                             busy_o,
  output logic                             overflow_o
);

  // A per-beat lane sum is a full product width plus enough bits to add LANES products
  localparam int PSUM_W = 2 * DATA_WIDTH + $clog2(LANES);
  localparam logic [BEAT_W-1:0] MAX_BEATS_C = BEAT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic [BEAT_W-1:0]     cnt_q, cnt_d;
  logic [PSUM_W-1:0]     psum_q, psum_d;
  logic                  pvalid_q, pvalid_d;
  logic                  last_q, last_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  overflow_q, overflow_d;
  logic [PSUM_W-1:0]     lane_sum;
  logic                  start_ok;

  // Unsigned lane-wise multiply of the current beat, summed at full width
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + (PSUM_W'(mem_row_i[k]) * PSUM_W'(weight_i[k]));
    end
  end

  assign start_ok = start && (beats_i != '0) && (beats_i <= MAX_BEATS_C);

  // Next-state logic for the IDLE -> ACCUM -> HOLD flow and the two-stage datapath
  always_comb begin
    state_d        = state_q;
    beats_d        = beats_q;
    cnt_d          = cnt_q;
    psum_d         = psum_q;
    pvalid_d       = 1'b0;
    last_d         = 1'b0;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overflow_d     = overflow_q;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          beats_d    = beats_i;
          acc_d      = '0;
          cnt_d      = '0;
          overflow_d = 1'b0;
          state_d    = ACCUM;
        end
      end

      ACCUM: begin
        if (data_valid) begin
          if (cnt_q < beats_q) begin
            psum_d   = lane_sum;
            pvalid_d = 1'b1;
            cnt_d    = cnt_q + BEAT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        // The counter already includes the beat whose psum is in flight, so equality marks the last one
        if (pvalid_q) begin
          acc_d = acc_q + ACC_WIDTH'(psum_q);
          if (cnt_q == beats_q) begin
            last_d = 1'b1;
          end
        end
        if (last_q) begin
          result_d       = acc_q;
          result_valid_d = 1'b1;
          state_d        = HOLD;
        end
      end

      HOLD: begin
        if (data_valid) begin
          overflow_d = 1'b1;
        end
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops everything so no partial result escapes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      beats_q        <= '0;
      cnt_q          <= '0;
      psum_q         <= '0;
      pvalid_q       <= 1'b0;
      last_q         <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      beats_q        <= beats_d;
      cnt_q          <= cnt_d;
      psum_q         <= psum_d;
      pvalid_q       <= pvalid_d;
      last_q         <= last_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign result_o     = result_q;
  assign result_valid = result_valid_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_row_dot_accum.sv
// tb_row_dot_accum
// Drives directed and randomized accumulation jobs into row_dot_accum and
// compares every observed output against a behavioural dot-product model.

module tb_row_dot_accum;

  localparam int DW  = 8;
  localparam int LN  = 3;
  localparam int MB  = 8;
  localparam int BW  = 4;
  localparam int AW  = 22;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [BW-1:0]           beats_i;
  logic                    data_valid;
  logic [LN-1:0][DW-1:0]   mem_row_i;
  logic [LN-1:0][DW-1:0]   weight_i;
  logic [AW-1:0]           result_o;
  logic                    result_valid;
  logic                    result_ready;
  logic                    busy_o;
  logic                    overflow_o;

  int tests_run;
  int tests_failed;

  int unsigned rows[MB][LN];
  int unsigned wts[MB][LN];
  int          gaps[MB];
  bit          exp_ovf;

  row_dot_accum #(
    .DATA_WIDTH(DW),
    .LANES(LN),
    .MAX_BEATS(MB),
    .BEAT_W(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .beats_i(beats_i),
    .data_valid(data_valid),
    .mem_row_i(mem_row_i),
    .weight_i(weight_i),
    .result_o(result_o),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy_o(busy_o),
    .overflow_o(overflow_o)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, got, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, then lets one rising edge pass and settles
  task automatic applyStimulus(input bit st, input logic [BW-1:0] bt, input bit dv, input bit rdy,
                               input logic [LN*DW-1:0] row, input logic [LN*DW-1:0] wt);
    start        = st;
    beats_i      = bt;
    data_valid   = dv;
    result_ready = rdy;
    mem_row_i    = row;
    weight_i     = wt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LN*DW-1:0] rnd24();
    return LN*DW'($urandom);
  endfunction

  function automatic logic [LN*DW-1:0] packLanes(input int b, input bit is_wt);
    logic [LN*DW-1:0] v;
    v = '0;
    for (int k = 0; k < LN; k++) begin
      v[k*DW +: DW] = is_wt ? DW'(wts[b][k]) : DW'(rows[b][k]);
    end
    return v;
  endfunction

  // Reference result: plain sum of all lane products over the job's beats
  function automatic longint unsigned dotModel(input int nb);
    longint unsigned s;
    s = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < LN; k++) begin
        s += longint'(rows[b][k]) * longint'(wts[b][k]);
      end
    end
    return s;
  endfunction

  // Runs one complete job: start, gapped beats, latency check, hold, handshake
  task automatic runJob(input int nb, input int hold_cycles, input bit acc_drop,
                        input bit hold_drop, input bit mid_start, output longint unsigned res);
    longint unsigned exp;
    bit dv;
    exp = dotModel(nb);
    res = exp;

    applyStimulus(1'b1, BW'(nb), 1'b0, 1'b0, rnd24(), rnd24());
    exp_ovf = 1'b0;
    checkOutput("start_busy", 64'(busy_o), 64'd1);
    checkOutput("start_ovf", 64'(overflow_o), 64'(exp_ovf));

    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < gaps[b]; g++) begin
        applyStimulus(mid_start, BW'($urandom_range(1, MB)), 1'b0, 1'b0, rnd24(), rnd24());
        checkOutput("gap_valid", 64'(result_valid), 64'd0);
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0, packLanes(b, 1'b0), packLanes(b, 1'b1));
      checkOutput("beat_busy", 64'(busy_o), 64'd1);
    end

    applyStimulus(1'b0, '0, acc_drop, 1'b0, rnd24(), rnd24());
    if (acc_drop) exp_ovf = 1'b1;
    checkOutput("lat1_valid", 64'(result_valid), 64'd0);

    applyStimulus(mid_start, BW'(1), 1'b0, 1'b0, rnd24(), rnd24());
    checkOutput("lat2_valid", 64'(result_valid), 64'd1);
    checkOutput("result", 64'(result_o), exp);
    checkOutput("result_ovf", 64'(overflow_o), 64'(exp_ovf));

    for (int h = 0; h < hold_cycles; h++) begin
      dv = hold_drop && (h == 1);
      applyStimulus(mid_start, BW'(2), dv, 1'b0, rnd24(), rnd24());
      if (dv) exp_ovf = 1'b1;
      checkOutput("hold_valid", 64'(result_valid), 64'd1);
      checkOutput("hold_result", 64'(result_o), exp);
      checkOutput("hold_ovf", 64'(overflow_o), 64'(exp_ovf));
    end

    applyStimulus(1'b0, '0, 1'b0, 1'b1, rnd24(), rnd24());
    checkOutput("hs_valid", 64'(result_valid), 64'd0);
    checkOutput("hs_busy", 64'(busy_o), 64'd0);
    checkOutput("hs_result", 64'(result_o), exp);
    checkOutput("hs_ovf", 64'(overflow_o), 64'(exp_ovf));
  endtask

  // Main sequence: reset, directed plan items, then randomized jobs
  initial begin
    longint unsigned res;
    tests_run    = 0;
    tests_failed = 0;
    exp_ovf      = 1'b0;
    rst          = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom), BW'($urandom), 1'($urandom), 1'($urandom), rnd24(), rnd24());
      checkOutput("rst_valid", 64'(result_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);
      checkOutput("rst_ovf", 64'(overflow_o), 64'd0);
      checkOutput("rst_result", 64'(result_o), 64'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Single beat
    rows[0] = '{10, 20, 30};
    wts[0]  = '{1, 2, 3};
    gaps[0] = 0;
    runJob(1, 2, 1'b0, 1'b0, 1'b0, res);
    checkOutput("single_140", 64'(result_o), 64'd140);

    // Gapped beats
    for (int b = 0; b < 3; b++) begin
      rows[b] = '{b + 1, b + 1, b + 1};
      wts[b]  = '{1, 1, 1};
    end
    gaps[0] = 0; gaps[1] = 2; gaps[2] = 1;
    runJob(3, 1, 1'b0, 1'b0, 1'b0, res);
    checkOutput("gapped_18", 64'(result_o), 64'd18);
    checkOutput("gapped_ovf", 64'(overflow_o), 64'd0);

    // Maximum operands over the maximum beat count
    for (int b = 0; b < MB; b++) begin
      rows[b] = '{255, 255, 255};
      wts[b]  = '{255, 255, 255};
      gaps[b] = 0;
    end
    runJob(MB, 0, 1'b0, 1'b0, 1'b0, res);
    checkOutput("max_1560600", 64'(result_o), 64'd1560600);

    // Backpressure with a dropped beat in HOLD
    for (int b = 0; b < 2; b++) begin
      rows[b] = '{1, 1, 1};
      wts[b]  = '{1, 1, 1};
      gaps[b] = 0;
    end
    runJob(2, 5, 1'b0, 1'b1, 1'b0, res);
    checkOutput("bp_6", 64'(result_o), 64'd6);
    checkOutput("bp_ovf_sticky", 64'(overflow_o), 64'd1);

    // Illegal starts and idle beats leave the block idle and the flag alone
    applyStimulus(1'b1, BW'(0), 1'b0, 1'b0, rnd24(), rnd24());
    checkOutput("start0_busy", 64'(busy_o), 64'd0);
    applyStimulus(1'b1, BW'(9), 1'b0, 1'b0, rnd24(), rnd24());
    checkOutput("start9_busy", 64'(busy_o), 64'd0);
    checkOutput("start9_ovf", 64'(overflow_o), 64'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, rnd24(), rnd24());
    checkOutput("idle_dv_busy", 64'(busy_o), 64'd0);
    checkOutput("idle_dv_ovf", 64'(overflow_o), 64'd1);

    // Start pulses during ACCUM are ignored; a new accepted start clears the flag
    for (int b = 0; b < 4; b++) begin
      rows[b] = '{$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
      wts[b]  = '{$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
      gaps[b] = 1;
    end
    runJob(4, 2, 1'b0, 1'b0, 1'b1, res);

    // Reset asserted mid-accumulation clears outputs before the next edge
    applyStimulus(1'b1, BW'(3), 1'b0, 1'b0, rnd24(), rnd24());
    applyStimulus(1'b0, '0, 1'b1, 1'b0, rnd24(), rnd24());
    applyStimulus(1'b0, '0, 1'b1, 1'b0, rnd24(), rnd24());
    applyStimulus(1'b0, '0, 1'b1, 1'b0, rnd24(), rnd24());
    applyStimulus(1'b0, '0, 1'b1, 1'b0, rnd24(), rnd24());
    checkOutput("pre_rst_ovf", 64'(overflow_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 64'(result_valid), 64'd0);
    checkOutput("midrst_busy", 64'(busy_o), 64'd0);
    checkOutput("midrst_ovf", 64'(overflow_o), 64'd0);
    checkOutput("midrst_result", 64'(result_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ovf = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("postrst_valid", 64'(result_valid), 64'd0);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      int nb;
      nb = $urandom_range(1, MB);
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < LN; k++) begin
          rows[b][k] = $urandom_range(0, 255);
          wts[b][k]  = $urandom_range(0, 255);
        end
        gaps[b] = $urandom_range(0, 2);
      end
      runJob(nb, $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), res);
      applyStimulus(1'b0, '0, 1'($urandom), 1'b0, rnd24(), rnd24());
      checkOutput("rand_idle_ovf", 64'(overflow_o), 64'(exp_ovf));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
